uart_prog_loader: RTL and testbench

Parametrised successor to the single-stream program input: accepts received UART bytes, buffers them in a small FIFO and writes them into program RAM only while RAM access is granted. It supports a legacy raw mode and a framed mode with explicit load address, length and optional checksum. It holds the CPU off RAM during a load and pulses the CPU reset only after a load completes successfully. It sits between the UART receiver and the RAM arbiter, next to the CPU reset logic.

---
 rtl/uart_prog_pkg.sv | 19 +
 rtl/prog_byte_fifo.sv | 51 +++++
 rtl/uart_prog_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_prog_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddrH,
        StAddrL,
        StLenH,
        StLenL,
        StPayload,
        StCheck,
        StDrain,
        StResetCpu
    } state_e;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/prog_byte_fifo.sv
// Synchronous 8-bit byte FIFO; a push into a full FIFO is accepted only when a pop happens in
// the same cycle.
module prog_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Loads UART bytes into program RAM in raw or framed mode, holding the CPU off RAM meanwhile.
// Define UART_PROG_CHECKSUM_EN to require a trailing checksum byte in framed mode.
module uart_prog_loader
    import uart_prog_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(16'h0600),
    parameter bit                FRAMED     = 1'b1,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter int unsigned       TIMEOUT    = 2000,
    parameter int unsigned       RESET_HOLD = 160
) (
    input  logic              clk_ram,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_strobe,
    input  logic              ram_grant,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              write_en,
    output logic              ask_for_ram,
    output logic              end_of_data,
    output logic              load_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned HW = $clog2(RESET_HOLD + 1);
`ifdef UART_PROG_CHECKSUM_EN
    localparam state_e POST_PAYLOAD = StCheck;
`else
    localparam state_e POST_PAYLOAD = StDrain;
`endif

    state_e            r_state;
    logic              r_ask;
    logic              r_eod;
    logic              r_err;
    logic              r_write_en;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_addr_h;
    logic [15:0]       r_len;
    logic [TW-1:0]     r_idle_cnt;
    logic [HW-1:0]     r_hold_cnt;
`ifdef UART_PROG_CHECKSUM_EN
    logic [7:0]        r_sum;
    logic [7:0]        w_sum_next;
    assign w_sum_next = r_sum + rx_data;
`endif

    logic        w_empty;
    logic        w_full;
    logic [7:0]  w_fifo_data;
    logic        w_pop;
    logic        w_accept;
    logic        w_overflow;
    logic        w_push;
    logic        w_idle_max;
    logic        w_abortable;
    logic        w_timeout;
    logic [15:0] w_len_next;

    assign w_pop       = ram_grant && !w_empty;
    assign w_accept    = rx_strobe && ((r_state == StPayload) || (!FRAMED && r_state == StIdle));
    assign w_overflow  = w_accept && w_full && !w_pop;
    assign w_push      = w_accept && !w_overflow;
    assign w_idle_max  = (r_idle_cnt == TW'(TIMEOUT - 1));
    assign w_abortable = r_state inside {StAddrH, StAddrL, StLenH, StLenL, StPayload, StCheck};
    assign w_timeout   = w_idle_max && !rx_strobe && w_abortable;
    assign w_len_next  = {r_len[15:8], rx_data};

    prog_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk_ram),
        .rst_n  (reset),
        .i_push (w_push),
        .i_data (rx_data),
        .i_pop  (w_pop),
        .o_data (w_fifo_data),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    always_ff @(posedge clk_ram or negedge reset) begin
        if (!reset) begin
            r_write_en <= 1'b0;
            r_waddr    <= BASE_ADDR;
            r_wdata    <= 8'h00;
        end else begin
            r_write_en <= w_pop;
            if (w_pop) begin
                r_waddr <= r_ptr;
                r_wdata <= w_fifo_data;
            end
        end
    end

    always_ff @(posedge clk_ram or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_ask      <= 1'b0;
            r_eod      <= 1'b0;
            r_err      <= 1'b0;
            r_ptr      <= BASE_ADDR;
            r_addr_h   <= 8'h00;
            r_len      <= 16'h0000;
            r_idle_cnt <= '0;
            r_hold_cnt <= '0;
`ifdef UART_PROG_CHECKSUM_EN
            r_sum      <= 8'h00;
`endif
        end else begin
            if (rx_strobe)        r_idle_cnt <= '0;
            else if (!w_idle_max) r_idle_cnt <= r_idle_cnt + TW'(1);
            if (w_pop) r_ptr <= r_ptr + ADDR_W'(1);
`ifdef UART_PROG_CHECKSUM_EN
            if (rx_strobe) r_sum <= w_sum_next;
`endif
            if (w_overflow) begin
                r_err   <= 1'b1;
                r_state <= StIdle;
            end else if (w_timeout) begin
                // Raw streams end on silence; framed loads treat it as an aborted frame.
                if (FRAMED) begin
                    r_err   <= 1'b1;
                    r_state <= StIdle;
                end else begin
                    r_state <= StDrain;
                end
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (rx_strobe) begin
                            if (!FRAMED) begin
                                r_ask   <= 1'b1;
                                r_ptr   <= BASE_ADDR;
                                r_state <= StPayload;
                            end else if (rx_data == SYNC_BYTE) begin
                                r_ask   <= 1'b1;
                                r_state <= StAddrH;
`ifdef UART_PROG_CHECKSUM_EN
                                r_sum   <= 8'h00;
`endif
                            end
                        end
                    end
                    StAddrH: begin
                        if (rx_strobe) begin
                            r_addr_h <= rx_data;
                            r_state  <= StAddrL;
                        end
                    end
                    StAddrL: begin
                        if (rx_strobe) begin
                            r_ptr   <= ADDR_W'({r_addr_h, rx_data});
                            r_state <= StLenH;
                        end
                    end
                    StLenH: begin
                        if (rx_strobe) begin
                            r_len[15:8] <= rx_data;
                            r_state     <= StLenL;
                        end
                    end
                    StLenL: begin
                        if (rx_strobe) begin
                            r_len   <= w_len_next;
                            r_state <= (w_len_next == 16'h0000) ? POST_PAYLOAD : StPayload;
                        end
                    end
                    StPayload: begin
                        if (FRAMED && rx_strobe) begin
                            r_len <= r_len - 16'h0001;
                            if (r_len == 16'h0001) r_state <= POST_PAYLOAD;
                        end
                    end
                    StCheck: begin
`ifdef UART_PROG_CHECKSUM_EN
                        if (rx_strobe) begin
                            if (w_sum_next == 8'h00) begin
                                r_state <= StDrain;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= StIdle;
                            end
                        end
`else
                        r_state <= StIdle;
`endif
                    end
                    StDrain: begin
                        if (w_empty) begin
                            r_ask      <= 1'b0;
                            r_eod      <= 1'b1;
                            r_err      <= 1'b0;
                            r_hold_cnt <= '0;
                            r_state    <= StResetCpu;
                        end
                    end
                    StResetCpu: begin
                        if (r_hold_cnt == HW'(RESET_HOLD - 1)) begin
                            r_eod   <= 1'b0;
                            r_state <= StIdle;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HW'(1);
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign waddr       = r_waddr;
    assign wdata       = r_wdata;
    assign write_en    = r_write_en;
    assign ask_for_ram = r_ask;
    assign end_of_data = r_eod;
    assign load_err    = r_err;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: one framed and one raw instance share clock and reset.
module tb_uart_prog_loader;

    localparam int unsigned F_TIMEOUT = 40;
    localparam int unsigned F_HOLD    = 160;
    localparam int unsigned R_TIMEOUT = 30;
    localparam int unsigned R_HOLD    = 20;
    localparam logic [15:0] BASE      = 16'h0600;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  fx_data = 8'h00;
    logic [7:0]  rw_data = 8'h00;
    logic        fx_stb = 1'b0;
    logic        rw_stb = 1'b0;
    logic        fx_grant = 1'b1;
    logic        rw_grant = 1'b1;
    logic [15:0] fx_waddr, rw_waddr;
    logic [7:0]  fx_wdata, rw_wdata;
    logic        fx_we, rw_we, fx_ask, rw_ask, fx_eod, rw_eod, fx_err, rw_err;

    wr_t qf[$];
    wr_t qr[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  f_eod_cnt = 0;
    int  r_eod_cnt = 0;
    int  f_run = 0;
    int  r_run = 0;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .FRAMED(1'b1), .TIMEOUT(F_TIMEOUT), .RESET_HOLD(F_HOLD)
    ) dut_f (
        .clk_ram(clk), .reset(rst_n), .rx_data(fx_data), .rx_strobe(fx_stb),
        .ram_grant(fx_grant), .waddr(fx_waddr), .wdata(fx_wdata), .write_en(fx_we),
        .ask_for_ram(fx_ask), .end_of_data(fx_eod), .load_err(fx_err)
    );

    uart_prog_loader #(
        .FRAMED(1'b0), .TIMEOUT(R_TIMEOUT), .RESET_HOLD(R_HOLD)
    ) dut_r (
        .clk_ram(clk), .reset(rst_n), .rx_data(rw_data), .rx_strobe(rw_stb),
        .ram_grant(rw_grant), .waddr(rw_waddr), .wdata(rw_wdata), .write_en(rw_we),
        .ask_for_ram(rw_ask), .end_of_data(rw_eod), .load_err(rw_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: every write pops the scoreboard; every end_of_data pulse is measured.
    always @(negedge clk) begin
        wr_t e;
        if (!rst_n) begin
            f_run = 0;
        end else begin
            if (fx_we) begin
                chk("f_write_expected", 32'(qf.size() != 0), 1);
                if (qf.size() != 0) begin
                    e = qf.pop_front();
                    chk("f_waddr", 32'(fx_waddr), 32'(e.a));
                    chk("f_wdata", 32'(fx_wdata), 32'(e.d));
                end
            end
            if (fx_eod) begin
                if (f_run == 0) f_eod_cnt++;
                f_run++;
            end else if (f_run != 0) begin
                chk("f_eod_len", 32'(f_run), F_HOLD);
                f_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (!rst_n) begin
            r_run = 0;
        end else begin
            if (rw_we) begin
                chk("r_write_expected", 32'(qr.size() != 0), 1);
                if (qr.size() != 0) begin
                    e = qr.pop_front();
                    chk("r_waddr", 32'(rw_waddr), 32'(e.a));
                    chk("r_wdata", 32'(rw_wdata), 32'(e.d));
                end
            end
            if (rw_eod) begin
                if (r_run == 0) r_eod_cnt++;
                r_run++;
            end else if (r_run != 0) begin
                chk("r_eod_len", 32'(r_run), R_HOLD);
                r_run = 0;
            end
        end
    end

    task automatic send_byte(input bit raw, input logic [7:0] b, input int gap);
        @(posedge clk);
        #1;
        if (raw) begin
            rw_data = b;
            rw_stb  = 1'b1;
        end else begin
            fx_data = b;
            fx_stb  = 1'b1;
        end
        @(posedge clk);
        #1;
        rw_stb = 1'b0;
        fx_stb = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    function automatic void expect_write(input bit raw, input logic [15:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        if (raw) qr.push_back(w);
        else     qf.push_back(w);
    endfunction

    // Framed load: optional non-sync noise, header, payload, checksum when enabled.
    task automatic send_frame(input logic [15:0] addr, input logic [7:0] pl[$], input bit corrupt,
                              input int noise);
        logic [7:0]  sum;
        logic [7:0]  nb;
        logic [15:0] len;
        len = 16'(pl.size());
        for (int i = 0; i < noise; i++) begin
            nb = 8'($urandom_range(0, 255));
            if (nb == 8'hA5) nb = 8'h5A;
            send_byte(0, nb, $urandom_range(0, 2));
        end
        send_byte(0, 8'hA5, $urandom_range(0, 2));
        send_byte(0, addr[15:8], $urandom_range(0, 2));
        send_byte(0, addr[7:0], $urandom_range(0, 2));
        send_byte(0, len[15:8], $urandom_range(0, 2));
        send_byte(0, len[7:0], $urandom_range(0, 2));
        sum = addr[15:8] + addr[7:0] + len[15:8] + len[7:0];
        for (int i = 0; i < pl.size(); i++) begin
            expect_write(0, addr + 16'(i), pl[i]);
            sum = sum + pl[i];
            send_byte(0, pl[i], $urandom_range(0, 2));
        end
`ifdef UART_PROG_CHECKSUM_EN
        send_byte(0, 8'h00 - sum + {7'd0, corrupt}, 0);
`else
        if (corrupt) $display("checksum disabled: frame sent without checksum byte");
`endif
    endtask

    task automatic expect_good(input bit raw);
        bit    ok;
        string p;
        p  = raw ? "r" : "f";
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = raw ? rw_eod : fx_eod;
        end
        chk({p, "_eod_rise"}, 32'(ok), 1);
        chk({p, "_ask_at_eod"}, 32'(raw ? rw_ask : fx_ask), 0);
        chk({p, "_err_at_eod"}, 32'(raw ? rw_err : fx_err), 0);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = !(raw ? rw_eod : fx_eod);
        end
        chk({p, "_eod_fall"}, 32'(ok), 1);
        chk({p, "_writes_done"}, 32'(raw ? qr.size() : qf.size()), 0);
    endtask

    task automatic check_reset_values();
        chk("rst_f_waddr", 32'(fx_waddr), 32'(BASE));
        chk("rst_f_wdata", 32'(fx_wdata), 0);
        chk("rst_f_we", 32'(fx_we), 0);
        chk("rst_f_ask", 32'(fx_ask), 0);
        chk("rst_f_eod", 32'(fx_eod), 0);
        chk("rst_f_err", 32'(fx_err), 0);
        chk("rst_r_waddr", 32'(rw_waddr), 32'(BASE));
        chk("rst_r_ask", 32'(rw_ask), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0]  pl[$];
        logic [7:0]  hdr[$];
        logic [7:0]  d;
        logic [15:0] a;
        int          saved;
        int          n;

        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        pl.delete();
        pl.push_back(8'h11);
        pl.push_back(8'h22);
        pl.push_back(8'h33);
        send_frame(16'h0200, pl, 1'b0, 0);
        expect_good(0);

`ifdef UART_PROG_CHECKSUM_EN
        saved = f_eod_cnt;
        send_frame(16'h0200, pl, 1'b1, 0);
        repeat (20) @(negedge clk);
        chk("f_cks_err", 32'(fx_err), 1);
        chk("f_cks_ask", 32'(fx_ask), 1);
        chk("f_cks_no_eod", 32'(f_eod_cnt), 32'(saved));
        chk("f_cks_writes", 32'(qf.size()), 0);
`endif

        pl.delete();
        send_frame(16'h1234, pl, 1'b0, 3);
        expect_good(0);

        pl.push_back(8'($urandom_range(0, 255)));
        pl.push_back(8'($urandom_range(0, 255)));
        send_frame(16'hFFFF, pl, 1'b0, 0);
        expect_good(0);

        // Frame stalls after the first address byte.
        saved = f_eod_cnt;
        send_byte(0, 8'hA5, 0);
        send_byte(0, 8'h01, 0);
        repeat (F_TIMEOUT + 20) @(negedge clk);
        chk("f_to_err", 32'(fx_err), 1);
        chk("f_to_ask", 32'(fx_ask), 1);
        chk("f_to_no_eod", 32'(f_eod_cnt), 32'(saved));

        pl.delete();
        for (int i = 0; i < 4; i++) pl.push_back(8'($urandom_range(0, 255)));
        send_frame(16'($urandom_range(0, 65535)), pl, 1'b0, 0);
        expect_good(0);

        // Five payload bytes into a four-deep FIFO with no grant: the fifth is dropped.
        fx_grant = 1'b0;
        saved    = f_eod_cnt;
        hdr.delete();
        hdr.push_back(8'hA5);
        hdr.push_back(8'h00);
        hdr.push_back(8'h30);
        hdr.push_back(8'h00);
        hdr.push_back(8'h05);
        for (int i = 0; i < 5; i++) send_byte(0, hdr[i], 0);
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(0, 255));
            if (i < 4) expect_write(0, 16'h0030 + 16'(i), d);
            send_byte(0, d, 0);
        end
        @(negedge clk);
        chk("f_ovf_err", 32'(fx_err), 1);
        chk("f_ovf_ask", 32'(fx_ask), 1);
        chk("f_ovf_pending", 32'(qf.size()), 4);
        fx_grant = 1'b1;
        repeat (10) @(negedge clk);
        chk("f_ovf_drained", 32'(qf.size()), 0);
        chk("f_ovf_no_eod", 32'(f_eod_cnt), 32'(saved));

        for (int k = 0; k < 4; k++) begin
            pl.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
            send_frame(16'($urandom_range(0, 65535)), pl, 1'b0, $urandom_range(0, 2));
            expect_good(0);
        end

        // Asynchronous reset in the middle of a payload.
        hdr.delete();
        hdr.push_back(8'hA5);
        hdr.push_back(8'h01);
        hdr.push_back(8'h00);
        hdr.push_back(8'h00);
        hdr.push_back(8'h06);
        for (int i = 0; i < 5; i++) send_byte(0, hdr[i], 0);
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(0, 255));
            expect_write(0, 16'h0100 + 16'(i), d);
            send_byte(0, d, 0);
        end
        chk("f_mid_ask", 32'(fx_ask), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        qf.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pl.delete();
        for (int i = 0; i < 3; i++) pl.push_back(8'($urandom_range(0, 255)));
        send_frame(16'h4000, pl, 1'b0, 0);
        expect_good(0);

        // Raw mode: first byte raises ask the next cycle and is written two cycles after it.
        chk("r_ask_before", 32'(rw_ask), 0);
        expect_write(1, BASE, 8'h01);
        send_byte(1, 8'h01, 0);
        @(negedge clk);
        chk("r_ask_rise", 32'(rw_ask), 1);
        chk("r_we_lat1", 32'(rw_we), 0);
        @(negedge clk);
        chk("r_we_lat2", 32'(rw_we), 1);
        expect_write(1, BASE + 16'h0001, 8'h02);
        send_byte(1, 8'h02, 0);
        expect_good(1);

        n = $urandom_range(3, 10);
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom_range(0, 255));
            a = BASE + 16'(i);
            expect_write(1, a, d);
            send_byte(1, d, $urandom_range(0, 3));
        end
        expect_good(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
